// File: rtl/mem_arb_pkg.sv
// Shared types and the arbitration pick for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arb_port_t;

    typedef logic [2:0] addr_mode_t;

    // Instruction fetches carry no AddrMode of their own; present them as full-word accesses.
    localparam addr_mode_t IF_MODE = 3'b010;

    function automatic arb_port_t pick_port(
        input logic      if_req,
        input logic      dm_req,
        input arb_port_t last_grant,
        input logic      rr_en
    );
        arb_port_t gnt;
        if (if_req && dm_req) begin
            if (rr_en) begin
                gnt = (last_grant == GNT_IF) ? GNT_DM : GNT_IF;
            end else begin
                gnt = GNT_DM;
            end
        end else if (dm_req) begin
            gnt = GNT_DM;
        end else begin
            gnt = GNT_IF;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Per-transaction watchdog: cleared on load, counts while enabled, flags the last allowed cycle.
module mem_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: load has priority over increment.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (IF) and memory (DM) stages.
// Define ARB_RR_EN for round-robin conflict resolution; otherwise DM always wins conflicts.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [2:0]    dm_mode,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [2:0]    mem_mode,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_f,
    output logic          stall_m,
    output logic          err
);

`ifdef ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_t    state_q,      state_d;
    arb_port_t     last_grant_q, last_grant_d;
    logic          mem_req_q,    mem_req_d;
    logic          mem_we_q,     mem_we_d;
    addr_mode_t    mem_mode_q,   mem_mode_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [DW-1:0] mem_wdata_q,  mem_wdata_d;
    logic          if_valid_q,   if_valid_d;
    logic          dm_valid_q,   dm_valid_d;
    logic [DW-1:0] if_rdata_q,   if_rdata_d;
    logic [DW-1:0] dm_rdata_q,   dm_rdata_d;
    logic          err_q,        err_d;

    arb_port_t     gnt_s;
    logic          timer_load_s;
    logic          timer_en_s;
    logic          timer_expired_s;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load_s),
        .en      (timer_en_s),
        .expired (timer_expired_s)
    );

    // Next-state, operand capture and completion logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_mode_d   = mem_mode_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        err_d        = err_q;
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;
        gnt_s        = pick_port(if_req, dm_req, last_grant_q, RR_EN);

        case (state_q)
            IDLE: begin
                timer_load_s = 1'b1;
                // Requests seen during a valid pulse are the ones just completed, not new ones.
                if ((if_req || dm_req) && !if_valid_q && !dm_valid_q) begin
                    last_grant_d = gnt_s;
                    mem_req_d    = 1'b1;
                    if (gnt_s == GNT_DM) begin
                        state_d     = SERVE_DM;
                        mem_we_d    = dm_we;
                        mem_mode_d  = dm_mode;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        state_d     = SERVE_IF;
                        mem_we_d    = 1'b0;
                        mem_mode_d  = IF_MODE;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE_IF: begin
                timer_en_s = 1'b1;
                if (mem_ready) begin
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end else if (timer_expired_s) begin
                    if_rdata_d = '0;
                    if_valid_d = 1'b1;
                    err_d      = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d = SERVE_IF;
                end
            end
            SERVE_DM: begin
                timer_en_s = 1'b1;
                if (mem_ready) begin
                    dm_rdata_d = mem_we_q ? '0 : mem_rdata;
                    dm_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end else if (timer_expired_s) begin
                    dm_rdata_d = '0;
                    dm_valid_d = 1'b1;
                    err_d      = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d = SERVE_DM;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_IF;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_mode_q   <= 3'b000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_mode_q   <= mem_mode_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_valid_q   <= if_valid_d;
            dm_valid_q   <= dm_valid_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            err_q        <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_mode  = mem_mode_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign err       = err_q;
    assign stall_f   = if_req & ~if_valid_q;
    assign stall_m   = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_valid;
    logic [2:0]    dm_mode;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_req, mem_we, mem_ready;
    logic [2:0]    mem_mode;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          stall_f, stall_m, err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_mode(dm_mode), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_m(stall_m), .err(err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit rr_en;

    // Transaction-level model: one outstanding access, its age in memory-request cycles,
    // and the completion it produced on the last edge.
    bit            m_busy, m_port, m_last, m_if_v, m_dm_v, m_err;
    int            m_age;
    logic          m_we;
    logic [2:0]    m_mode;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rd, m_dm_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_update();
        bit blocked;
        logic [DW-1:0] rd;
        blocked = m_if_v || m_dm_v;
        m_if_v = 1'b0;
        m_dm_v = 1'b0;
        if (!rst) begin
            m_busy = 1'b0; m_age = 0; m_last = 1'b0; m_err = 1'b0;
        end else if (m_busy) begin
            if (mem_ready || m_age == TIMEOUT) begin
                rd = (!mem_ready || (m_port && m_we)) ? '0 : mem_rdata;
                if (!mem_ready) m_err = 1'b1;
                if (m_port) begin m_dm_v = 1'b1; m_dm_rd = rd; end
                else begin m_if_v = 1'b1; m_if_rd = rd; end
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end else if (!blocked && (if_req || dm_req)) begin
            if (if_req && dm_req) m_port = rr_en ? ~m_last : 1'b1;
            else m_port = dm_req;
            m_last = m_port;
            m_busy = 1'b1;
            m_age = 1;
            if (m_port) begin
                m_we = dm_we; m_mode = dm_mode; m_addr = dm_addr; m_wdata = dm_wdata;
            end else begin
                m_we = 1'b0; m_mode = 3'b000; m_addr = if_addr; m_wdata = '0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("mem_req", mem_req, m_busy);
        if (m_busy) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            if (m_port) begin
                chk("mem_mode", mem_mode, m_mode);
                chk("mem_wdata", mem_wdata, m_wdata);
            end
        end
        chk("if_valid", if_valid, m_if_v);
        chk("dm_valid", dm_valid, m_dm_v);
        if (m_if_v) chk("if_rdata", if_rdata, m_if_rd);
        if (m_dm_v) chk("dm_rdata", dm_rdata, m_dm_rd);
        chk("err", err, m_err);
        chk("stall_f", stall_f, if_req & ~m_if_v);
        chk("stall_m", stall_m, dm_req & ~m_dm_v);
    end

    task automatic wait_valid(input bit dm, input int budget, output int n);
        n = 0;
        while (((dm ? dm_valid : if_valid) !== 1'b1) && n < budget) begin
            step();
            n++;
        end
        chk("wait_valid_bound", (n < budget), 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int got[4];
        int ng;
        bit prev_req, prev_busy, hang;
`ifdef ARB_RR_EN
        rr_en = 1'b1;
`else
        rr_en = 1'b0;
`endif
        rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_mode = 3'b000; dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) step();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        rst = 1'b1;
        step();

        // IF-only load, memory answers two cycles after mem_req rises.
        if_req = 1'b1; if_addr = 32'h100;
        step();
        chk("t1_mem_req", mem_req, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        step();
        step();
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        chk("t1_if_valid", if_valid, 1'b1);
        chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        mem_ready = 1'b0; if_req = 1'b0;
        step();
        chk("t1_pulse_end", if_valid, 1'b0);
        chk("t1_stall_f", stall_f, 1'b0);

        // Simultaneous requests: the store is served first, then the fetch.
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b1; dm_mode = 3'b010; dm_addr = 32'h20; dm_wdata = 32'h55;
        step();
        chk("t2_mem_we", mem_we, 1'b1);
        chk("t2_mem_addr", mem_addr, 32'h20);
        chk("t2_mem_wdata", mem_wdata, 32'h55);
        mem_ready = 1'b1; mem_rdata = 32'h1234;
        step();
        chk("t2_dm_valid", dm_valid, 1'b1);
        chk("t2_dm_rdata", dm_rdata, 32'h0);
        mem_ready = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        step();
        chk("t2_bubble", mem_req, 1'b0);
        step();
        chk("t2_if_served", mem_addr, 32'h40);
        mem_ready = 1'b1;
        wait_valid(1'b0, 10, n);
        if_req = 1'b0; mem_ready = 1'b0;
        repeat (2) step();

        // Four back-to-back conflicts; each completed port immediately re-requests.
        if_req = 1'b1; if_addr = 32'h1000; dm_req = 1'b1; dm_addr = 32'h2000; dm_we = 1'b0;
        mem_ready = 1'b1; ng = 0; prev_req = 1'b0;
        for (int i = 0; i < 80 && ng < 4; i++) begin
            if (m_if_v) if_addr = if_addr + 32'h4;
            if (m_dm_v) dm_addr = dm_addr + 32'h4;
            mem_rdata = $urandom;
            step();
            if (mem_req && !prev_req) begin
                got[ng] = (mem_addr[13:12] == 2'b10) ? 1 : 0;
                ng++;
            end
            prev_req = mem_req;
        end
        chk("t3_grants_seen", ng, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_grant%0d", i), got[i], (rr_en && (i % 2 == 1)) ? 0 : 1);
        step();
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        repeat (3) step();

        // Hung memory: abort 16 cycles after mem_req rises, err becomes sticky.
        if_req = 1'b1; if_addr = 32'h300;
        step();
        wait_valid(1'b0, 40, n);
        chk("t4_timeout_latency", n, 16);
        chk("t4_if_rdata", if_rdata, 32'h0);
        chk("t4_err", err, 1'b1);
        if_req = 1'b0;
        step();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44; mem_ready = 1'b1; mem_rdata = 32'hCAFE;
        wait_valid(1'b1, 10, n);
        chk("t4_good_rdata", dm_rdata, 32'hCAFE);
        chk("t4_err_sticky", err, 1'b1);
        dm_req = 1'b0; mem_ready = 1'b0;
        step();

        // Reset while serving DM abandons the access; the held request is then served anew.
        dm_req = 1'b1; dm_addr = 32'h88;
        step();
        step();
        rst = 1'b0;
        step();
        chk("t5_mem_req", mem_req, 1'b0);
        chk("t5_dm_valid", dm_valid, 1'b0);
        chk("t5_err", err, 1'b0);
        rst = 1'b1;
        step();
        chk("t5_regrant", mem_req, 1'b1);
        mem_ready = 1'b1; mem_rdata = 32'h77;
        step();
        chk("t5_dm_valid2", dm_valid, 1'b1);
        chk("t5_dm_rdata", dm_rdata, 32'h77);
        dm_req = 1'b0;
        // mem_ready pulses while idle produce nothing.
        repeat (4) step();
        chk("t6_idle_if", if_valid, 1'b0);
        chk("t6_idle_dm", dm_valid, 1'b0);
        mem_ready = 1'b0;

        // Ready on the last allowed cycle wins over the timeout.
        if_req = 1'b1; if_addr = 32'h500;
        step();
        repeat (15) step();
        mem_ready = 1'b1; mem_rdata = 32'hABCD;
        step();
        chk("t6_ready_wins_valid", if_valid, 1'b1);
        chk("t6_ready_wins_rdata", if_rdata, 32'hABCD);
        chk("t6_ready_wins_err", err, 1'b0);
        if_req = 1'b0; mem_ready = 1'b0;
        step();

        // Randomized traffic.
        prev_busy = 1'b0; hang = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (if_req && m_if_v) begin
                if_req = $urandom_range(0, 1) == 0;
                if_addr = $urandom;
            end else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (dm_req && m_dm_v) begin
                dm_req = $urandom_range(0, 1) == 0;
                dm_we = $urandom_range(0, 1); dm_mode = 3'($urandom_range(0, 7));
                dm_addr = $urandom; dm_wdata = $urandom;
            end else if (!dm_req && $urandom_range(0, 3) == 0) begin
                dm_req = 1'b1; dm_we = $urandom_range(0, 1); dm_mode = 3'($urandom_range(0, 7));
                dm_addr = $urandom; dm_wdata = $urandom;
            end
            if (m_busy && !prev_busy) hang = $urandom_range(0, 9) == 0;
            prev_busy = m_busy;
            mem_ready = m_busy ? (!hang && $urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
